// File: rtl/write_back_stage_pkg.sv
// Shared processor definitions used by the write-back stage: FSM state
// encoding, the reserved PC register index and the retire counter width.
package write_back_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_MEM = 2'b01,
    ST_HALT     = 2'b10
  } wb_state_e;

  // Integer register index that aliases the program counter; never written.
  localparam logic [3:0] PC_REG_IDX = 4'hF;

  localparam int RETIRED_BITS = 16;

  // Width of a counter able to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    if (max_val < 2) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/write_back_stage_if.sv
// Bundle of the MEM-stage result, load-return and register-file write
// signals around the write-back stage. master = upstream/driver side,
// slave = the write-back stage itself.
interface write_back_stage_if #(
  parameter int REGI_BITS = 4,
  parameter int VECT_BITS = 2,
  parameter int REGI_SIZE = 16,
  parameter int VECT_SIZE = 8,
  parameter int ELEM_SIZE = 8
);
  localparam int VW = ELEM_SIZE * VECT_SIZE;

  logic                 valid_i;
  logic                 int_we_req_i;
  logic                 vec_we_req_i;
  logic [REGI_BITS-1:0] int_dest_i;
  logic [VECT_BITS-1:0] vec_dest_i;
  logic [REGI_SIZE-1:0] int_result_i;
  logic [VW-1:0]        vec_result_i;
  logic                 mem_read_i;
  logic                 mem_rvalid_i;
  logic [VW-1:0]        mem_rdata_i;
  logic                 end_i;

  logic                 int_we_o;
  logic                 vec_we_o;
  logic [REGI_BITS-1:0] int_dest_o;
  logic [VECT_BITS-1:0] vec_dest_o;
  logic [REGI_SIZE-1:0] int_wd_o;
  logic [VW-1:0]        vec_wd_o;
  logic                 stall_o;
  logic                 halted_o;
  logic                 err_o;
  logic [15:0]          retired_o;

  modport master (
    output valid_i, int_we_req_i, vec_we_req_i, int_dest_i, vec_dest_i,
           int_result_i, vec_result_i, mem_read_i, mem_rvalid_i,
           mem_rdata_i, end_i,
    input  int_we_o, vec_we_o, int_dest_o, vec_dest_o, int_wd_o, vec_wd_o,
           stall_o, halted_o, err_o, retired_o
  );

  modport slave (
    input  valid_i, int_we_req_i, vec_we_req_i, int_dest_i, vec_dest_i,
           int_result_i, vec_result_i, mem_read_i, mem_rvalid_i,
           mem_rdata_i, end_i,
    output int_we_o, vec_we_o, int_dest_o, vec_dest_o, int_wd_o, vec_wd_o,
           stall_o, halted_o, err_o, retired_o
  );

endinterface

// File: rtl/write_back_stage.sv
// Write-back stage: registers ALU results into the integer/vector register
// files one cycle after they arrive, waits (with a timeout) for load data,
// halts on the end-of-program marker and counts retired writes.
module write_back_stage
  import write_back_stage_pkg::*;
#(
  parameter int REGI_BITS   = 4,
  parameter int VECT_BITS   = 2,
  parameter int REGI_SIZE   = 16,
  parameter int VECT_SIZE   = 8,
  parameter int ELEM_SIZE   = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  write_back_stage_if.slave wb
);

  localparam int VW    = ELEM_SIZE * VECT_SIZE;
  localparam int CNT_W = cnt_width(MEM_TIMEOUT);
  localparam logic [REGI_BITS-1:0] PC_DEST     = REGI_BITS'(PC_REG_IDX);
  localparam logic [CNT_W-1:0]     TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

  wb_state_e state_q, state_d;

  // Wait counter and fields latched when a load is accepted.
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]     wait_cnt_inc_s;
  logic                 lat_int_req_q, lat_int_req_d;
  logic                 lat_vec_req_q, lat_vec_req_d;
  logic [REGI_BITS-1:0] lat_int_dest_q, lat_int_dest_d;
  logic [VECT_BITS-1:0] lat_vec_dest_q, lat_vec_dest_d;

  // Output registers.
  logic                 int_we_q, int_we_d;
  logic                 vec_we_q, vec_we_d;
  logic [REGI_BITS-1:0] int_dest_q, int_dest_d;
  logic [VECT_BITS-1:0] vec_dest_q, vec_dest_d;
  logic [REGI_SIZE-1:0] int_wd_q, int_wd_d;
  logic [VW-1:0]        vec_wd_q, vec_wd_d;
  logic                 stall_q, stall_d;
  logic                 halted_q, halted_d;
  logic                 err_q, err_d;
  logic [RETIRED_BITS-1:0] retired_q, retired_d;

  // Address/data selected for a write in the current cycle.
  logic [REGI_BITS-1:0] cand_int_dest_s;
  logic [VECT_BITS-1:0] cand_vec_dest_s;
  logic [REGI_SIZE-1:0] cand_int_wd_s;
  logic [VW-1:0]        cand_vec_wd_s;

  assign wait_cnt_inc_s = wait_cnt_q + CNT_W'(1);

  // Next-state, write selection and wait-counter logic.
  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    lat_int_req_d   = lat_int_req_q;
    lat_vec_req_d   = lat_vec_req_q;
    lat_int_dest_d  = lat_int_dest_q;
    lat_vec_dest_d  = lat_vec_dest_q;
    int_we_d        = 1'b0;
    vec_we_d        = 1'b0;
    err_d           = err_q;
    cand_int_dest_s = wb.int_dest_i;
    cand_vec_dest_s = wb.vec_dest_i;
    cand_int_wd_s   = wb.int_result_i;
    cand_vec_wd_s   = wb.vec_result_i;

    case (state_q)
      ST_IDLE: begin
        if (wb.valid_i) begin
          if (wb.end_i) begin
            // End marker wins over a load: only a plain result is written.
            int_we_d = wb.int_we_req_i && !wb.mem_read_i && (wb.int_dest_i != PC_DEST);
            vec_we_d = wb.vec_we_req_i && !wb.mem_read_i;
            state_d  = ST_HALT;
          end else if (wb.mem_read_i) begin
            lat_int_req_d  = wb.int_we_req_i;
            lat_vec_req_d  = wb.vec_we_req_i;
            lat_int_dest_d = wb.int_dest_i;
            lat_vec_dest_d = wb.vec_dest_i;
            wait_cnt_d     = {CNT_W{1'b0}};
            state_d        = ST_WAIT_MEM;
          end else begin
            int_we_d = wb.int_we_req_i && (wb.int_dest_i != PC_DEST);
            vec_we_d = wb.vec_we_req_i;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT_MEM: begin
        cand_int_dest_s = lat_int_dest_q;
        cand_vec_dest_s = lat_vec_dest_q;
        cand_int_wd_s   = wb.mem_rdata_i[REGI_SIZE-1:0];
        cand_vec_wd_s   = wb.mem_rdata_i;
        if (wb.mem_rvalid_i) begin
          // Load data beats a coincident timeout.
          int_we_d = lat_int_req_q && (lat_int_dest_q != PC_DEST);
          vec_we_d = lat_vec_req_q;
          state_d  = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_inc_s;
          if (wait_cnt_inc_s == TIMEOUT_VAL) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_MEM;
          end
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Address/data registers only move when their file is actually written.
    if (int_we_d) begin
      int_dest_d = cand_int_dest_s;
      int_wd_d   = cand_int_wd_s;
    end else begin
      int_dest_d = int_dest_q;
      int_wd_d   = int_wd_q;
    end

    if (vec_we_d) begin
      vec_dest_d = cand_vec_dest_s;
      vec_wd_d   = cand_vec_wd_s;
    end else begin
      vec_dest_d = vec_dest_q;
      vec_wd_d   = vec_wd_q;
    end

    stall_d  = (state_d == ST_WAIT_MEM);
    halted_d = (state_d == ST_HALT);

    // A write counts as retired once its enable cycle has completed.
    if (int_we_q || vec_we_q) begin
      retired_d = retired_q + 16'd1;
    end else begin
      retired_d = retired_q;
    end
  end

  // State, latched-load fields and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      wait_cnt_q     <= {CNT_W{1'b0}};
      lat_int_req_q  <= 1'b0;
      lat_vec_req_q  <= 1'b0;
      lat_int_dest_q <= {REGI_BITS{1'b0}};
      lat_vec_dest_q <= {VECT_BITS{1'b0}};
      int_we_q       <= 1'b0;
      vec_we_q       <= 1'b0;
      int_dest_q     <= {REGI_BITS{1'b0}};
      vec_dest_q     <= {VECT_BITS{1'b0}};
      int_wd_q       <= {REGI_SIZE{1'b0}};
      vec_wd_q       <= {VW{1'b0}};
      stall_q        <= 1'b0;
      halted_q       <= 1'b0;
      err_q          <= 1'b0;
      retired_q      <= 16'd0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      lat_int_req_q  <= lat_int_req_d;
      lat_vec_req_q  <= lat_vec_req_d;
      lat_int_dest_q <= lat_int_dest_d;
      lat_vec_dest_q <= lat_vec_dest_d;
      int_we_q       <= int_we_d;
      vec_we_q       <= vec_we_d;
      int_dest_q     <= int_dest_d;
      vec_dest_q     <= vec_dest_d;
      int_wd_q       <= int_wd_d;
      vec_wd_q       <= vec_wd_d;
      stall_q        <= stall_d;
      halted_q       <= halted_d;
      err_q          <= err_d;
      retired_q      <= retired_d;
    end
  end

  assign wb.int_we_o   = int_we_q;
  assign wb.vec_we_o   = vec_we_q;
  assign wb.int_dest_o = int_dest_q;
  assign wb.vec_dest_o = vec_dest_q;
  assign wb.int_wd_o   = int_wd_q;
  assign wb.vec_wd_o   = vec_wd_q;
  assign wb.stall_o    = stall_q;
  assign wb.halted_o   = halted_q;
  assign wb.err_o      = err_q;
  assign wb.retired_o  = retired_q;

endmodule

// File: tb/tb_write_back_stage.sv
// Bench for write_back_stage: a transaction-level model checked against the
// DUT every cycle, plus directed scenarios with literal expectations.
module tb_write_back_stage;

  localparam int MEM_TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  write_back_stage_if bus ();

  write_back_stage #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Expected outputs.
  logic        e_int_we = 1'b0, e_vec_we = 1'b0;
  logic        e_stall = 1'b0, e_halted = 1'b0, e_err = 1'b0;
  logic [3:0]  e_int_dest = 4'd0;
  logic [1:0]  e_vec_dest = 2'd0;
  logic [15:0] e_int_wd = 16'd0;
  logic [63:0] e_vec_wd = 64'd0;
  logic [15:0] e_retired = 16'd0;

  // Outstanding load as the model sees it.
  bit          ld_pending = 1'b0;
  int          ld_waited  = 0;
  bit          ld_int_req = 1'b0, ld_vec_req = 1'b0;
  logic [3:0]  ld_idest = 4'd0;
  logic [1:0]  ld_vdest = 2'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_write(input bit ireq, input bit vreq, input logic [3:0] idst,
                             input logic [1:0] vdst, input logic [15:0] idat,
                             input logic [63:0] vdat);
    if (ireq && idst != 4'hF) begin
      e_int_we = 1'b1; e_int_dest = idst; e_int_wd = idat;
    end
    if (vreq) begin
      e_vec_we = 1'b1; e_vec_dest = vdst; e_vec_wd = vdat;
    end
  endtask

  task automatic model_step();
    if (!rst) begin
      e_int_we = 0; e_vec_we = 0; e_stall = 0; e_halted = 0; e_err = 0;
      e_int_dest = 0; e_vec_dest = 0; e_int_wd = 0; e_vec_wd = 0; e_retired = 0;
      ld_pending = 0; ld_waited = 0;
    end else begin
      if (e_int_we || e_vec_we) e_retired = e_retired + 16'd1;
      e_int_we = 0; e_vec_we = 0;
      if (e_halted) begin
        // halted: nothing happens until reset
      end else if (ld_pending) begin
        if (bus.mem_rvalid_i) begin
          model_write(ld_int_req, ld_vec_req, ld_idest, ld_vdest,
                      bus.mem_rdata_i[15:0], bus.mem_rdata_i);
          ld_pending = 0;
        end else begin
          ld_waited++;
          if (ld_waited == MEM_TIMEOUT) begin
            e_err = 1'b1; ld_pending = 0;
          end
        end
      end else if (bus.valid_i) begin
        if (bus.end_i) begin
          if (!bus.mem_read_i)
            model_write(bus.int_we_req_i, bus.vec_we_req_i, bus.int_dest_i, bus.vec_dest_i,
                        bus.int_result_i, bus.vec_result_i);
          e_halted = 1'b1;
        end else if (bus.mem_read_i) begin
          ld_pending = 1; ld_waited = 0;
          ld_int_req = bus.int_we_req_i; ld_vec_req = bus.vec_we_req_i;
          ld_idest = bus.int_dest_i; ld_vdest = bus.vec_dest_i;
        end else begin
          model_write(bus.int_we_req_i, bus.vec_we_req_i, bus.int_dest_i, bus.vec_dest_i,
                      bus.int_result_i, bus.vec_result_i);
        end
      end
      e_stall = ld_pending;
    end
  endtask

  // Model update at each edge, then compare all outputs shortly after.
  always @(posedge clk) begin
    model_step();
    #1;
    chk("m_int_we",   64'(bus.int_we_o),   64'(e_int_we));
    chk("m_vec_we",   64'(bus.vec_we_o),   64'(e_vec_we));
    chk("m_int_dest", 64'(bus.int_dest_o), 64'(e_int_dest));
    chk("m_vec_dest", 64'(bus.vec_dest_o), 64'(e_vec_dest));
    chk("m_int_wd",   64'(bus.int_wd_o),   64'(e_int_wd));
    chk("m_vec_wd",   bus.vec_wd_o,        e_vec_wd);
    chk("m_stall",    64'(bus.stall_o),    64'(e_stall));
    chk("m_halted",   64'(bus.halted_o),   64'(e_halted));
    chk("m_err",      64'(bus.err_o),      64'(e_err));
    chk("m_retired",  64'(bus.retired_o),  64'(e_retired));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit v, input bit ir, input bit vr, input logic [3:0] idst,
                       input logic [1:0] vdst, input logic [15:0] ires,
                       input logic [63:0] vres, input bit mr, input bit en);
    bus.valid_i = v; bus.int_we_req_i = ir; bus.vec_we_req_i = vr;
    bus.int_dest_i = idst; bus.vec_dest_i = vdst;
    bus.int_result_i = ires; bus.vec_result_i = vres;
    bus.mem_read_i = mr; bus.end_i = en;
  endtask

  task automatic idle();
    drive(0, 0, 0, 4'd0, 2'd0, 16'd0, 64'd0, 0, 0);
    bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = 64'd0;
  endtask

  initial begin
    logic [15:0] r0;
    int n;
    idle();
    rst = 1'b0;
    step(); step();
    chk("rst_retired", 64'(bus.retired_o), 64'd0);
    chk("rst_stall",   64'(bus.stall_o),   64'd0);
    chk("rst_int_we",  64'(bus.int_we_o),  64'd0);
    rst = 1'b1;
    step();

    // Plain integer write to r3.
    drive(1, 1, 0, 4'd3, 2'd0, 16'h1234, 64'd0, 0, 0);
    step();
    chk("int_we",   64'(bus.int_we_o),   64'd1);
    chk("int_dest", 64'(bus.int_dest_o), 64'd3);
    chk("int_wd",   64'(bus.int_wd_o),   64'h1234);
    idle(); step();
    chk("int_we_pulse", 64'(bus.int_we_o),  64'd0);
    chk("retired_1",    64'(bus.retired_o), 64'd1);
    chk("int_wd_hold",  64'(bus.int_wd_o),  64'h1234);

    // Dual write in one cycle.
    drive(1, 1, 1, 4'd7, 2'd3, 16'hBEEF, 64'hA5A5_5A5A_0F0F_F0F0, 0, 0);
    step();
    chk("dual_int_we", 64'(bus.int_we_o), 64'd1);
    chk("dual_vec_we", 64'(bus.vec_we_o), 64'd1);
    chk("dual_vec_wd", bus.vec_wd_o, 64'hA5A5_5A5A_0F0F_F0F0);

    // Valid without any request bit; stray rvalid in IDLE.
    drive(1, 0, 0, 4'd2, 2'd1, 16'h1111, 64'd5, 0, 0);
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'hFFFF;
    step();
    chk("noreq_int_we", 64'(bus.int_we_o), 64'd0);
    idle(); step();
    chk("noreq_retired", 64'(bus.retired_o), 64'd2);

    // PC destination blocked, vector write still proceeds.
    r0 = bus.retired_o;
    drive(1, 1, 1, 4'hF, 2'd1, 16'hDEAD, 64'h1111_2222_3333_4444, 0, 0);
    step();
    chk("pc_vec_we",   64'(bus.vec_we_o),   64'd1);
    chk("pc_int_we",   64'(bus.int_we_o),   64'd0);
    chk("pc_int_dest", 64'(bus.int_dest_o), 64'd7);
    idle(); step();
    chk("pc_retired", 64'(bus.retired_o), 64'(r0 + 16'd1));

    // Vector load to v2, data in the 4th stalled cycle.
    drive(1, 0, 1, 4'd0, 2'd2, 16'd0, 64'd0, 1, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("ld_stall", 64'(bus.stall_o), 64'd1);
      if (i == 3) begin
        idle();
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'h0102030405060708;
      end else begin
        drive(1, 1, 0, 4'd5, 2'd0, 16'h7777, 64'd0, 0, 0);
      end
      step();
    end
    idle();
    chk("ld_vec_we",   64'(bus.vec_we_o),   64'd1);
    chk("ld_vec_dest", 64'(bus.vec_dest_o), 64'd2);
    chk("ld_vec_wd",   bus.vec_wd_o,        64'h0102030405060708);
    chk("ld_unstall",  64'(bus.stall_o),    64'd0);

    // Integer load, data immediately: low 16 bits of load data.
    drive(1, 1, 0, 4'd9, 2'd0, 16'd0, 64'd0, 1, 0);
    step();
    idle(); bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'hCAFE_0000_0000_4321;
    step();
    idle();
    chk("ild_int_wd", 64'(bus.int_wd_o), 64'h4321);
    step();

    // Load that never returns: times out after MEM_TIMEOUT stalled cycles.
    r0 = bus.retired_o;
    drive(1, 1, 0, 4'd4, 2'd0, 16'd0, 64'd0, 1, 0);
    step();
    idle();
    n = 0;
    for (int i = 0; i < 20 && !bus.err_o; i++) begin
      if (bus.stall_o) n++;
      step();
    end
    chk("to_err",     64'(bus.err_o),     64'd1);
    chk("to_cycles",  64'(n),             64'(MEM_TIMEOUT));
    chk("to_stall",   64'(bus.stall_o),   64'd0);
    chk("to_int_we",  64'(bus.int_we_o),  64'd0);
    chk("to_retired", 64'(bus.retired_o), 64'(r0));

    // Data arriving on the timeout cycle still completes the load.
    drive(1, 0, 1, 4'd0, 2'd3, 16'd0, 64'd0, 1, 0);
    step();
    idle();
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      if (i == MEM_TIMEOUT - 1) begin
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'h0BAD_F00D_1234_5678;
      end
      step();
    end
    idle();
    chk("race_vec_we", 64'(bus.vec_we_o), 64'd1);
    chk("race_vec_wd", bus.vec_wd_o, 64'h0BAD_F00D_1234_5678);
    step();

    // Reset during the 2nd WAIT_MEM cycle abandons the load.
    drive(1, 0, 1, 4'd0, 2'd1, 16'd0, 64'd0, 1, 0);
    step();
    idle(); step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'h5555_6666_7777_8888;
    step();
    idle();
    chk("rstw_vec_we",  64'(bus.vec_we_o),  64'd0);
    chk("rstw_vec_wd",  bus.vec_wd_o,       64'd0);
    chk("rstw_err",     64'(bus.err_o),     64'd0);
    chk("rstw_retired", 64'(bus.retired_o), 64'd0);
    chk("rstw_stall",   64'(bus.stall_o),   64'd0);

    // End of program with a write to r5, then everything is ignored.
    drive(1, 1, 0, 4'd5, 2'd0, 16'h55AA, 64'd0, 0, 1);
    step();
    chk("end_int_we",   64'(bus.int_we_o),   64'd1);
    chk("end_int_dest", 64'(bus.int_dest_o), 64'd5);
    chk("end_halted",   64'(bus.halted_o),   64'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 4'(i), 2'(i), 16'(i + 1), 64'(i + 9), i[0], 0);
      step();
      chk("halt_int_we", 64'(bus.int_we_o), 64'd0);
      chk("halt_vec_we", 64'(bus.vec_we_o), 64'd0);
      chk("halt_stall",  64'(bus.stall_o),  64'd0);
    end
    idle(); step();
    chk("halt_retired", 64'(bus.retired_o), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/write_back_stage.md
WRITE_BACK_STAGE -- requirements
Module: write_back_stage

Interface
REQ-001 SHALL take parameter REGI_BITS, default 4, integer register address width.
REQ-002 SHALL take parameter VECT_BITS, default 2, vector register address width.
REQ-003 SHALL take parameter REGI_SIZE, default 16, integer data width.
REQ-004 SHALL take parameter VECT_SIZE, default 8, lanes per vector.
REQ-005 SHALL take parameter ELEM_SIZE, default 8, bits per lane.
REQ-006 SHALL take parameter MEM_TIMEOUT, default 15, maximum cycles spent waiting for load data.
REQ-007 SHALL have one clock and a synchronous, active-low reset on these ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-low reset.
REQ-008 SHALL have these ports (VW = ELEM_SIZE*VECT_SIZE):
- valid_i  in  1  result from MEM stage present.
- int_we_req_i  in  1  result targets the integer file.
- vec_we_req_i  in  1  result targets the vector file.
- int_dest_i  in  REGI_BITS  integer destination.
- vec_dest_i  in  VECT_BITS  vector destination.
- int_result_i  in  REGI_SIZE  integer ALU result.
- vec_result_i  in  VW  vector ALU result.
- mem_read_i  in  1  load; data comes from memory.
- mem_rvalid_i  in  1  load data valid.
- mem_rdata_i  in  VW  load data.
- end_i  in  1  end-of-program marker.
- int_we_o  out  1  integer file write enable.
- vec_we_o  out  1  vector file write enable.
- int_dest_o  out  REGI_BITS  integer write address.
- vec_dest_o  out  VECT_BITS  vector write address.
- int_wd_o  out  REGI_SIZE  integer write data.
- vec_wd_o  out  VW  vector write data.
- stall_o  out  1  upstream hold.
- halted_o  out  1  program ended.
- err_o  out  1  load timeout, sticky.
- retired_o  out  16  count of completed writes.

Function
REQ-009 SHALL implement an FSM with states IDLE, WAIT_MEM and HALT.
REQ-010 SHALL, in IDLE with valid_i=1 and mem_read_i=0, register the write: on the next cycle assert int_we_o and/or vec_we_o for exactly 1 cycle, with int_wd_o=int_result_i and vec_wd_o=vec_result_i (latency 1).
REQ-011 SHALL, when both request bits are set, write both register files in the same cycle.
REQ-012 SHALL, when valid_i=1 with no request bit set, perform no write and leave retired_o unchanged.
REQ-013 SHALL never write integer destination 4'hF, which is reserved for the PC: int_we_o stays 0 and any vector write still proceeds.
REQ-014 SHALL, in IDLE with valid_i=1 and mem_read_i=1, latch the destination and request bits, go to WAIT_MEM, and clear the wait counter.
REQ-015 SHALL hold stall_o=1 in WAIT_MEM and stall_o=0 elsewhere; inputs presented while stalled are ignored.
REQ-016 SHALL, in WAIT_MEM when mem_rvalid_i=1, write on the next cycle with vec_wd_o=mem_rdata_i and int_wd_o=mem_rdata_i[REGI_SIZE-1:0], then return to IDLE.
REQ-017 SHALL increment the wait counter on every WAIT_MEM cycle without mem_rvalid_i.
REQ-018 SHALL, when the wait counter reaches MEM_TIMEOUT, set err_o, drop the load with no write, and return to IDLE.
REQ-019 SHALL give mem_rvalid_i priority over the timeout when both occur in the same cycle, so the load completes.
REQ-020 SHALL ignore mem_rvalid_i outside WAIT_MEM.
REQ-021 SHALL, in IDLE with valid_i=1 and end_i=1, complete that result's non-load write, enter HALT, and assert halted_o from the next cycle.
REQ-022 SHALL, in HALT, hold all write enables at 0, keep stall_o=0, and leave HALT only on reset.
REQ-023 SHALL increment retired_o by 1 per cycle in which int_we_o or vec_we_o is asserted, wrapping 16'hFFFF to 0.
REQ-024 SHALL hold the data and address outputs at their last values when the write enables are 0.

Reset
REQ-025 SHALL, on rst=0 at a clock edge, go to IDLE and zero every output, wait counter, latched field and retired_o.
REQ-026 SHALL, when reset occurs during WAIT_MEM, abandon the pending load with no write.

Structure
REQ-027 SHALL take the FSM state enum and the 4'hF PC register index from the shared processor package.
REQ-028 SHALL use no sub-module; the FSM, output register and counters are written inline.

Verification
REQ-029 The bench SHALL check: valid_i=1, int_we_req_i=1, int_dest_i=3, int_result_i=16'h1234 -> next cycle int_we_o=1, int_dest_o=3, int_wd_o=16'h1234, and retired_o=1 after that write.
REQ-030 The bench SHALL check: vector load to v2, mem_rvalid_i after 4 cycles with 64'h0102030405060708 -> stall_o=1 for 4 cycles, then vec_we_o=1, vec_dest_o=2, vec_wd_o=64'h0102030405060708.
REQ-031 The bench SHALL check: load with no mem_rvalid_i -> err_o=1 after 15 WAIT_MEM cycles, no write, back in IDLE, stall_o=0.
REQ-032 The bench SHALL check: both request bits, int_dest_i=4'hF, vec_dest_i=1 -> vec_we_o=1, int_we_o=0, retired_o incremented by 1.
REQ-033 The bench SHALL check: valid_i=1 with end_i=1 and a write to r5 -> r5 written, halted_o=1, and subsequent valid_i cause no writes.
REQ-034 The bench SHALL check: rst=0 in cycle 2 of WAIT_MEM, then mem_rvalid_i=1 -> no write, and all outputs are 0.
